// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
// Purpose: FSM state encoding and default operand width used by the adder,
//          its interface and the testbench.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for the bit-serial adder
// Purpose: groups the start/operand inputs and busy/done/result outputs.
// Signals: start, a, b, cin   - driven by the operand producer (master)
//          busy, done, sum, carry - driven by the adder (slave)
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, carry
  );

endinterface

// File: rtl/fa.sv
// rtl/fa.sv - one-bit full-adder cell
// Purpose: combinational s = a ^ b ^ ci, co = majority(a, b, ci).
// Ports: a, b, ci (inputs); s, co (outputs).
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one result bit per clock through a single fa cell
// Purpose: computes {carry, sum} = a + b + cin over WIDTH clocks after start.
// Ports: clk   - rising-edge clock
//        rst_n - asynchronous active-low reset
//        bus   - serial_adder_if slave: start/a/b/cin in, busy/done/sum/carry out
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             creg;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_bit;
  logic             accept;
  logic             last;

  fa u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (creg),
    .s  (s_bit),
    .co (c_bit)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at acc[0].
  // Written as shift-then-overwrite so WIDTH = 1 needs no special slice.
  always_comb begin
    acc_next            = acc >> 1;
    acc_next[WIDTH-1]   = s_bit;
  end

  // A start in DONE is accepted just like in IDLE; in RUN it is ignored.
  assign accept = bus.start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  // FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (last) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Operand shift registers, partial-sum accumulator, running carry and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      creg <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      sa   <= bus.a;
      sb   <= bus.b;
      creg <= bus.cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      acc  <= acc_next;
      creg <= c_bit;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Result registers change only on the completion edge and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (last) begin
      sum_q   <= acc_next;
      carry_q <= c_bit;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random self-checking bench for serial_adder
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; start is sampled on the next rising edge and the
  // task returns at the falling edge right after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.cin   = 1'($urandom);
  endtask

  // Counts falling edges until done is seen (bounded), and busy-high samples on the way.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W:0] exp, input bit check_timing);
    int lat;
    int bcnt;
    issue(a, b, cin);
    wait_done(lat, bcnt);
    chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    chk({tag, "_result"}, 32'({bus.carry, bus.sum}), 32'(exp));
    if (check_timing) begin
      chk({tag, "_latency"}, 32'(lat), 32'd8);
      chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int dcnt;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result", 32'({bus.carry, bus.sum}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Carry out and timing
    run_op("carry_out", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("result_held_idle", 32'({bus.carry, bus.sum}), 32'h100);

    // Carry in
    run_op("carry_in_a5", 8'hA5, 8'h5A, 1'b1, 9'h100, 1'b1);
    @(negedge clk);
    run_op("carry_in_zero", 8'h00, 8'h00, 1'b1, 9'h001, 1'b1);
    @(negedge clk);

    // Start during RUN is ignored
    issue(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    chk("ignore_latency", 32'(lat), 32'd5);
    chk("ignore_result", 32'({bus.carry, bus.sum}), 32'h046);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    chk("ignore_no_second_op", 32'(dcnt), 32'd0);

    // Back-to-back: start held during the DONE cycle
    run_op("b2b_first", 8'h0F, 8'h01, 1'b0, 9'h010, 1'b0);
    issue(8'h80, 8'h80, 1'b0);
    chk("b2b_done_dropped", 32'(bus.done), 32'd0);
    chk("b2b_busy_rose", 32'(bus.busy), 32'd1);
    repeat (4) @(negedge clk);
    chk("b2b_first_held", 32'({bus.carry, bus.sum}), 32'h010);
    wait_done(lat, bcnt);
    chk("b2b_latency", 32'(lat + 4), 32'd8);
    chk("b2b_second", 32'({bus.carry, bus.sum}), 32'h100);
    @(negedge clk);

    // Reset in the middle of RUN
    issue(8'h77, 8'h11, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", 32'({bus.carry, bus.sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    run_op("after_reset", 8'h03, 8'h04, 1'b0, 9'h007, 1'b1);
    @(negedge clk);

    // Random operands and start gaps
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op("random", ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'h00, rc}, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
